// File: rtl/ct_fcnvt_issue_ctrl.sv
// Vector FP convert issue control: issue buffer,
// EX1 launch and EX1-EX3 IID tracking to writeback.
module ct_fcnvt_issue_ctrl #(
  parameter int DEPTH  = 2,
  parameter int FUNC_W = 20,
  parameter int IID_W  = 7
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  input  logic              rf_cnvt_vld,
  input  logic [FUNC_W-1:0] rf_cnvt_func,
  input  logic [IID_W-1:0]  rf_cnvt_iid,
  output logic              rf_cnvt_rdy,
  input  logic              vfpu_wb_slot_busy,
  input  logic              rtu_yy_xx_flush,
  output logic [2:0]        dp_vfalu_ex1_pipex_sel,
  output logic [FUNC_W-1:0] ex1_cnvt_func,
  output logic [IID_W-1:0]  ex1_cnvt_iid,
  output logic              ex3_cnvt_wb_vld,
  output logic [IID_W-1:0]  ex3_cnvt_wb_iid,
  output logic              cnvt_pipe_idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic [PW-1:0]     wr_q;
  logic [PW-1:0]     rd_q;
  logic [FUNC_W-1:0] buf_func_q [DEPTH];
  logic [IID_W-1:0]  buf_iid_q  [DEPTH];

  logic              ex1_vld_q;
  logic              ex2_vld_q;
  logic              ex3_vld_q;
  logic [FUNC_W-1:0] ex1_func_q;
  logic [IID_W-1:0]  ex1_iid_q;
  logic [IID_W-1:0]  ex2_iid_q;
  logic [IID_W-1:0]  ex3_iid_q;

  logic push;
  logic pop;
  logic empty;

  assign empty       = (cnt_q == '0);
  assign rf_cnvt_rdy = (cnt_q != CW'(DEPTH));

  assign push = rf_cnvt_vld & rf_cnvt_rdy
              & ~rtu_yy_xx_flush;
  assign pop  = ~empty & ~vfpu_wb_slot_busy
              & ~rtu_yy_xx_flush;

  // Occupancy: net change only when exactly one of push/pop fires
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Issue buffer pointers and occupancy; flush empties the buffer
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      cnt_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
    end else if (rtu_yy_xx_flush) begin
      cnt_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
    end
  end

  // Issue buffer storage, written at the write pointer on accept
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_func_q[i] <= '0;
        buf_iid_q[i]  <= '0;
      end
    end else if (push) begin
      buf_func_q[wr_q] <= rf_cnvt_func;
      buf_iid_q[wr_q]  <= rf_cnvt_iid;
    end
  end

  // EX1-EX3 valid chain; never stalls, only flush kills it
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      ex1_vld_q <= 1'b0;
      ex2_vld_q <= 1'b0;
      ex3_vld_q <= 1'b0;
    end else if (rtu_yy_xx_flush) begin
      ex1_vld_q <= 1'b0;
      ex2_vld_q <= 1'b0;
      ex3_vld_q <= 1'b0;
    end else begin
      ex1_vld_q <= pop;
      ex2_vld_q <= ex1_vld_q;
      ex3_vld_q <= ex2_vld_q;
    end
  end

  // Stage data follows its valid; func only needed in EX1
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      ex1_func_q <= '0;
      ex1_iid_q  <= '0;
      ex2_iid_q  <= '0;
      ex3_iid_q  <= '0;
    end else begin
      if (pop) begin
        ex1_func_q <= buf_func_q[rd_q];
        ex1_iid_q  <= buf_iid_q[rd_q];
      end
      if (ex1_vld_q) ex2_iid_q <= ex1_iid_q;
      if (ex2_vld_q) ex3_iid_q <= ex2_iid_q;
    end
  end

  assign dp_vfalu_ex1_pipex_sel = {ex1_vld_q, 2'b00};
  assign ex1_cnvt_func   = ex1_func_q;
  assign ex1_cnvt_iid    = ex1_iid_q;
  assign ex3_cnvt_wb_vld = ex3_vld_q;
  assign ex3_cnvt_wb_iid = ex3_iid_q;
  assign cnvt_pipe_idle  = empty & ~ex1_vld_q
                         & ~ex2_vld_q & ~ex3_vld_q;

endmodule
